// File: rtl/mm_slot_scheduler.sv
// mm_slot_scheduler
//   Shares one 4-slot pipelined Montgomery multiplier between N_REQ
//   requesters. The multiplier runs a free-running round counter. Slot k
//   accepts a new job only in round k*SLOT_PITCH, so each slot is decided one
//   round earlier (its pre-window), with registered outputs. Every job is
//   tagged {1, slot, id} in mm_info_ini. The multiplier returns that tag with
//   its done pulse, and the tag routes rsp_valid back to the requester that
//   owns the job. Only control is handled here: the operand buses are muxed
//   outside this block using op_sel.
//
//   Optional feature macro: MMS_WATCHDOG_EN.
//     When it is defined, each slot has a 16-bit busy-cycle watchdog that
//     sets a sticky err_timeout bit.
//     When it is undefined, err_timeout is tied to 0.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset (shared with multiplier)
//   req           level request per requester, held until gnt
//   gnt           one-hot 1-cycle grant, coincident with mm_en
//   rsp_valid     one-hot 1-cycle pulse: the owner's result is on now_z
//   op_sel        last granted requester (external operand mux select)
//   mm_en         multiplier enable
//   mm_info_ini   job tag {1'b1, slot[1:0], id[4:0]}
//   mm_round      multiplier round counter
//   mm_flag       multiplier slot-occupied flags
//   mm_done       multiplier done pulse
//   mm_info_out   tag returned with mm_done
//   busy_slots    local slot occupancy
//   err_spurious  sticky: done with a bad or unknown tag
//   err_timeout   sticky per slot: watchdog expiry
module mm_slot_scheduler #(
  parameter int N_REQ      = 4,
  parameter int ROUND_MAX  = 17,
  parameter int SLOT_PITCH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] rsp_valid,
  output logic [4:0]       op_sel,
  output logic             mm_en,
  output logic [7:0]       mm_info_ini,
  input  logic [4:0]       mm_round,
  input  logic [3:0]       mm_flag,
  input  logic             mm_done,
  input  logic [7:0]       mm_info_out,
  output logic [3:0]       busy_slots,
  output logic             err_spurious,
  output logic [3:0]       err_timeout
);

  if (N_REQ < 1 || N_REQ > 32) begin : g_bad_nreq
    $error("N_REQ must be 1..32");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must fit the 16-bit watchdog");
  end

  // The round in which slot k is decided is one before its admission round.
  // It wraps to ROUND_MAX for slot 0.
  function automatic logic [4:0] pre_win(input int k);
    int w;
    w = k * SLOT_PITCH;
    if (w == 0) return 5'(ROUND_MAX);
    return 5'(w - 1);
  endfunction

  logic [N_REQ-1:0] outst, outst_nxt, elig, gnt_nxt, rsp_nxt;
  logic [31:0]      outst_ext;
  logic [4:0]       ptr, ptr_nxt, win_id, done_id;
  logic [1:0]       win_slot, done_slot;
  logic [3:0]       busy_nxt;
  logic             win_hit, found, issue, done_ok;

  assign elig = req & ~outst;

  // Find which slot, if any, is in its pre-window this cycle.
  always_comb begin
    win_hit  = 1'b0;
    win_slot = 2'd0;
    for (int k = 0; k < 4; k++)
      if (mm_round == pre_win(k)) begin
        win_hit  = 1'b1;
        win_slot = 2'(k);
      end
  end

  // Round-robin arbitration: the lowest eligible index at or after ptr wins.
  // If there is none, the lowest eligible index overall wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (!found && elig[i] && 5'(i) >= ptr) begin
        found  = 1'b1;
        win_id = 5'(i);
      end
    for (int i = 0; i < N_REQ; i++)
      if (!found && elig[i]) begin
        found  = 1'b1;
        win_id = 5'(i);
      end
  end

  // A slot is not reused while the multiplier still flags it (draining).
  assign issue   = win_hit & ~busy_slots[win_slot] & ~mm_flag[win_slot] & (|elig);
  assign ptr_nxt = (win_id == 5'(N_REQ - 1)) ? 5'd0 : win_id + 5'd1;

  // An id >= N_REQ indexes the zero-extended bits of outst_ext.
  // Such a done therefore reads as "not outstanding" and is treated as spurious.
  assign done_id   = mm_info_out[4:0];
  assign done_slot = mm_info_out[6:5];
  assign outst_ext = 32'(outst);
  assign done_ok   = mm_done & mm_info_out[7] & outst_ext[done_id];

  // Completion clears first, then issue sets.
  // The issue decision uses pre-update state, so a slot or requester freed
  // in this cycle is not picked until its next window.
  always_comb begin
    outst_nxt = outst;
    busy_nxt  = busy_slots;
    gnt_nxt   = '0;
    rsp_nxt   = '0;
    if (done_ok) busy_nxt[done_slot] = 1'b0;
    if (issue)   busy_nxt[win_slot]  = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (done_ok && 5'(i) == done_id) begin
        outst_nxt[i] = 1'b0;
        rsp_nxt[i]   = 1'b1;
      end
      if (issue && 5'(i) == win_id) begin
        outst_nxt[i] = 1'b1;
        gnt_nxt[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      outst        <= '0;
      busy_slots   <= '0;
      ptr          <= '0;
      gnt          <= '0;
      rsp_valid    <= '0;
      mm_en        <= 1'b0;
      op_sel       <= '0;
      mm_info_ini  <= '0;
      err_spurious <= 1'b0;
    end else begin
      outst      <= outst_nxt;
      busy_slots <= busy_nxt;
      gnt        <= gnt_nxt;
      rsp_valid  <= rsp_nxt;
      mm_en      <= issue;
      // Held between issues, so operands remain valid through the
      // multiplier's enable delay.
      if (issue) begin
        op_sel      <= win_id;
        mm_info_ini <= {1'b1, win_slot, win_id};
        ptr         <= ptr_nxt;
      end
      if (mm_done && !done_ok) err_spurious <= 1'b1;
    end

`ifdef MMS_WATCHDOG_EN
  // The count is cleared on issue and counts busy cycles.
  // The flag is raised on the edge where the count reaches TIMEOUT, which is
  // TIMEOUT cycles after the issue edge.
  // The count saturates there; the slot stays occupied until reset.
  for (genvar k = 0; k < 4; k++) begin : g_wd
    logic [15:0] cnt;
    logic        hit;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        hit <= 1'b0;
      end else begin
        if (issue && win_slot == 2'(k))
          cnt <= '0;
        else if (busy_slots[k] && cnt != 16'(TIMEOUT))
          cnt <= cnt + 16'd1;
        if (busy_slots[k] && cnt == 16'(TIMEOUT - 1))
          hit <= 1'b1;
      end
    assign err_timeout[k] = hit;
  end
`else
  assign err_timeout = 4'b0;
`endif

endmodule

// File: tb/tb_mm_slot_scheduler.sv
// Directed bench for mm_slot_scheduler (N_REQ=4, ROUND_MAX=17, SLOT_PITCH=4,
// TIMEOUT=64).
// The bench drives the multiplier's round counter itself, advancing it 1 time
// unit after every rising edge.
// A table holds per-round stimulus with hand-computed registered outputs.
// Hand-written sequences then cover reset, spurious tags and the watchdog.
module tb_mm_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, gnt, rsp_valid, mm_flag, busy_slots, err_timeout;
  logic [4:0] op_sel, mm_round;
  logic       mm_en, mm_done, err_spurious;
  logic [7:0] mm_info_ini, mm_info_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mm_slot_scheduler #(
    .N_REQ(4), .ROUND_MAX(17), .SLOT_PITCH(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .rsp_valid(rsp_valid),
    .op_sel(op_sel), .mm_en(mm_en), .mm_info_ini(mm_info_ini),
    .mm_round(mm_round), .mm_flag(mm_flag), .mm_done(mm_done),
    .mm_info_out(mm_info_out), .busy_slots(busy_slots),
    .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [4:0] at;    // round during which inputs are applied
    logic [3:0] req;
    logic       done;
    logic [7:0] info;
    logic [3:0] flag;
    logic [3:0] gnt;   // expected registered outputs one edge later
    logic       en;
    logic [7:0] ini;
    logic [4:0] sel;
    logic [3:0] rsp;
    logic [3:0] busy;
    logic       spur;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One clock: the multiplier counter advances on the same edge as the DUT.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) mm_round = 5'd0;
    else        mm_round = (mm_round == 5'd17) ? 5'd0 : mm_round + 5'd1;
  endtask

  task automatic wait_round(input logic [4:0] r);
    int n;
    n = 0;
    while (mm_round != r && n < 40) begin
      tick();
      n++;
    end
    if (mm_round != r) begin
      total++;
      bad++;
      $display("FAIL wait_round got=%0d want=%0d", mm_round, r);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".gnt"},  32'(gnt), 0);
    chk({tag, ".en"},   32'(mm_en), 0);
    chk({tag, ".ini"},  32'(mm_info_ini), 0);
    chk({tag, ".sel"},  32'(op_sel), 0);
    chk({tag, ".rsp"},  32'(rsp_valid), 0);
    chk({tag, ".busy"}, 32'(busy_slots), 0);
    chk({tag, ".spur"}, 32'(err_spurious), 0);
    chk({tag, ".tmo"},  32'(err_timeout), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mm_round = 5'd0;
    req = '0; mm_done = 1'b0; mm_info_out = '0; mm_flag = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] tmo_exp;

    //        at    req      dn  info   flag     gnt      en  ini    sel    rsp      busy     sp
    tbl[0]  = '{5'd5,  4'b0001, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 5'd0, 4'b0000, 4'b0000, 0}; // no window
    tbl[1]  = '{5'd7,  4'b0001, 0, 8'h00, 4'b0000, 4'b0001, 1, 8'hC0, 5'd0, 4'b0000, 4'b0100, 0}; // slot2 <- id0
    tbl[2]  = '{5'd8,  4'b0000, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'hC0, 5'd0, 4'b0000, 4'b0100, 0}; // pulse ends, tag held
    tbl[3]  = '{5'd11, 4'b1110, 0, 8'h00, 4'b0000, 4'b0010, 1, 8'hE1, 5'd1, 4'b0000, 4'b1100, 0}; // slot3 <- id1
    tbl[4]  = '{5'd17, 4'b1100, 0, 8'h00, 4'b0000, 4'b0100, 1, 8'h82, 5'd2, 4'b0000, 4'b1101, 0}; // slot0 <- id2
    tbl[5]  = '{5'd3,  4'b1000, 0, 8'h00, 4'b0000, 4'b1000, 1, 8'hA3, 5'd3, 4'b0000, 4'b1111, 0}; // slot1 <- id3, ptr wraps
    tbl[6]  = '{5'd5,  4'b0000, 1, 8'h82, 4'b0000, 4'b0000, 0, 8'hA3, 5'd3, 4'b0100, 4'b1110, 0}; // done id2 slot0
    tbl[7]  = '{5'd6,  4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'hA3, 5'd3, 4'b0000, 4'b1110, 1}; // tag invalid
    tbl[8]  = '{5'd7,  4'b0100, 1, 8'hC0, 4'b0000, 4'b0000, 0, 8'hA3, 5'd3, 4'b0001, 4'b1010, 1}; // done in slot2 pre-window
    tbl[9]  = '{5'd11, 4'b0100, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'hA3, 5'd3, 4'b0000, 4'b1010, 1}; // slot3 busy
    tbl[10] = '{5'd17, 4'b0100, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'hA3, 5'd3, 4'b0000, 4'b1010, 1}; // slot0 draining
    tbl[11] = '{5'd3,  4'b0100, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'hA3, 5'd3, 4'b0000, 4'b1010, 1}; // slot1 busy
    tbl[12] = '{5'd7,  4'b0100, 0, 8'h00, 4'b0000, 4'b0100, 1, 8'hC2, 5'd2, 4'b0000, 4'b1110, 1}; // slot2 next revolution
    tbl[13] = '{5'd17, 4'b0000, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'hC2, 5'd2, 4'b0000, 4'b1110, 1}; // free slot, no requester

    rst_n = 1'b0;
    mm_round = 5'd0;
    req = '0; mm_done = 1'b0; mm_info_out = '0; mm_flag = '0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;

    for (int e = 0; e < NV; e++) begin
      wait_round(tbl[e].at);
      req = tbl[e].req;
      mm_done = tbl[e].done;
      mm_info_out = tbl[e].info;
      mm_flag = tbl[e].flag;
      tick();
      mm_done = 1'b0;
      mm_info_out = '0;
      chk($sformatf("v%0d.gnt", e),  32'(gnt),          32'(tbl[e].gnt));
      chk($sformatf("v%0d.en", e),   32'(mm_en),        32'(tbl[e].en));
      chk($sformatf("v%0d.ini", e),  32'(mm_info_ini),  32'(tbl[e].ini));
      chk($sformatf("v%0d.sel", e),  32'(op_sel),       32'(tbl[e].sel));
      chk($sformatf("v%0d.rsp", e),  32'(rsp_valid),    32'(tbl[e].rsp));
      chk($sformatf("v%0d.busy", e), 32'(busy_slots),   32'(tbl[e].busy));
      chk($sformatf("v%0d.spur", e), 32'(err_spurious), 32'(tbl[e].spur));
    end

    // Asynchronous reset while jobs are in flight clears everything at once.
    #2;
    rst_n = 1'b0;
    mm_round = 5'd0;
    #1;
    check_zero("midjob");
    repeat (2) tick();
    rst_n = 1'b1;

    // Done for an id that has no job outstanding.
    wait_round(5'd5);
    mm_done = 1'b1; mm_info_out = 8'h82;
    tick();
    mm_done = 1'b0; mm_info_out = '0;
    chk("nojob.spur", 32'(err_spurious), 1);
    chk("nojob.rsp",  32'(rsp_valid), 0);
    chk("nojob.busy", 32'(busy_slots), 0);
    tick();
    chk("nojob.sticky", 32'(err_spurious), 1);

    // Done whose id is beyond N_REQ, with a real job outstanding in slot 1.
    do_reset();
    wait_round(5'd3);
    req = 4'b0001;
    tick();
    req = '0;
    chk("oor.issue", 32'(busy_slots), 4'b0010);
    mm_done = 1'b1; mm_info_out = 8'hA5;
    tick();
    mm_done = 1'b0; mm_info_out = '0;
    chk("oor.spur", 32'(err_spurious), 1);
    chk("oor.rsp",  32'(rsp_valid), 0);
    chk("oor.busy", 32'(busy_slots), 4'b0010);

    // Watchdog: issue into slot 0 and never return it.
    do_reset();
    wait_round(5'd17);
    req = 4'b0001;
    tick();
    req = '0;
    chk("wd.en",  32'(mm_en), 1);
    chk("wd.ini", 32'(mm_info_ini), 8'h80);
    repeat (63) tick();
    chk("wd.early", 32'(err_timeout), 0);
    tick();
`ifdef MMS_WATCHDOG_EN
    tmo_exp = 4'b0001;
`else
    tmo_exp = 4'b0000;
`endif
    chk("wd.expire", 32'(err_timeout), 32'(tmo_exp));
    chk("wd.busy",   32'(busy_slots), 4'b0001);
    #2;
    rst_n = 1'b0;
    mm_round = 5'd0;
    #1;
    check_zero("wdreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
